// File: rtl/seq_det_pkg.sv
// Shared widths and defaults for the multi-pattern serial detector.
// Imported by the slot and top modules.
package seq_det_pkg;

    localparam int DEF_NUM_PAT = 2;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    // Slot index width; a single slot still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Length field must hold 0..MAX_LEN inclusive.
    function automatic int len_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_slot.sv
// One programmable pattern slot: config, freshness counter,
// window compare and saturating hit counter.
import seq_det_pkg::*;

module seq_pattern_slot #(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_valid,
    input  logic [MAX_LEN-1:0] win,
    input  logic [LEN_W-1:0]   fill,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_en,
    input  logic               clr_count,
    output logic               hit,
    output logic [CNT_W-1:0]   count
);

    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [LEN_W-1:0]   len;
        logic               overlap;
        logic               en;
    } slot_cfg_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    slot_cfg_t        cfg;
    logic [LEN_W-1:0] since;
    logic             len_ok;
    logic             match;
    logic             ready;
    logic             fresh;
    logic [LEN_W:0]   fill_p1;
    logic [LEN_W:0]   since_p1;

    // Compare the low len bits of the window against the pattern.
    always_comb begin
        match = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < cfg.len && win[i] != cfg.pattern[i])
                match = 1'b0;
        end
        len_ok   = (cfg.len != '0) && (cfg.len <= LEN_MAX);
        fill_p1  = {1'b0, fill} + 1'b1;
        since_p1 = {1'b0, since} + 1'b1;
        ready    = fill_p1 >= {1'b0, cfg.len};
        fresh    = since_p1 >= {1'b0, cfg.len};
        hit      = x_valid & cfg.en & len_ok & match & ready
                 & (cfg.overlap | fresh);
    end

    // Config registers; a write lands at the edge, hit uses the old copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cfg <= '0;
        else if (cfg_we)
            cfg <= '{cfg_pattern, cfg_len, cfg_overlap, cfg_en};
    end

    // Bits seen since the last hit or rewrite, saturating at MAX_LEN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            since <= LEN_MAX;
        else if (cfg_we || hit)
            since <= '0;
        else if (x_valid && since != LEN_MAX)
            since <= since + 1'b1;
    end

    // Saturating hit counter; clear beats a same-cycle hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr_count)
            count <= '0;
        else if (hit && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/multi_pattern_seq_detector.sv
// Runtime-programmable multi-pattern serial bit detector.
// Shared history/fill, per-slot matchers, packed counters.
import seq_det_pkg::*;

module multi_pattern_seq_detector #(
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int IDX_W  = idx_w(NUM_PAT),
    localparam int LEN_W  = len_w(MAX_LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x_valid,
    input  logic                     x,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [MAX_LEN-1:0]       cfg_pattern,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_overlap,
    input  logic                     cfg_en,
    input  logic                     clr_count,
    output logic [NUM_PAT-1:0]       hit,
    output logic                     hit_any,
    output logic [NUM_PAT*CNT_W-1:0] hit_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] win;

    assign win     = {hist, x};
    assign hit_any = |hit;

    // Shift accepted bits into the history and track how full it is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (x_valid) begin
            hist <= win[MAX_LEN-2:0];
            if (fill != LEN_MAX)
                fill <= fill + 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PAT; p++) begin : g_slot
        logic sel;

        assign sel = cfg_we && (cfg_idx == IDX_W'(p));

        seq_pattern_slot #(
            .MAX_LEN (MAX_LEN),
            .CNT_W   (CNT_W),
            .LEN_W   (LEN_W)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .x_valid     (x_valid),
            .win         (win),
            .fill        (fill),
            .cfg_we      (sel),
            .cfg_pattern (cfg_pattern),
            .cfg_len     (cfg_len),
            .cfg_overlap (cfg_overlap),
            .cfg_en      (cfg_en),
            .clr_count   (clr_count),
            .hit         (hit[p]),
            .count       (hit_count[p*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_pattern_seq_detector.sv
// Scoreboard bench for multi_pattern_seq_detector against a
// stream-level reference model.
module tb_multi_pattern_seq_detector;
    import seq_det_pkg::*;

    localparam int NUM_PAT = 2;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = idx_w(NUM_PAT);
    localparam int LEN_W   = len_w(MAX_LEN);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     x_valid = 1'b0;
    logic                     x = 1'b0;
    logic                     cfg_we = 1'b0;
    logic [IDX_W-1:0]         cfg_idx = '0;
    logic [MAX_LEN-1:0]       cfg_pattern = '0;
    logic [LEN_W-1:0]         cfg_len = '0;
    logic                     cfg_overlap = 1'b0;
    logic                     cfg_en = 1'b0;
    logic                     clr_count = 1'b0;
    logic [NUM_PAT-1:0]       hit;
    logic                     hit_any;
    logic [NUM_PAT*CNT_W-1:0] hit_count;

    multi_pattern_seq_detector #(
        .NUM_PAT (NUM_PAT),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x_valid     (x_valid),
        .x           (x),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_en      (cfg_en),
        .clr_count   (clr_count),
        .hit         (hit),
        .hit_any     (hit_any),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_PAT-1:0]       hit;
        logic                     any;
        logic [NUM_PAT*CNT_W-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: recent stream bits, total bit count, and for each
    // slot the bit count at its last hit/rewrite (fresh-bit anchor).
    bit                 bits[$];
    int                 nbits;
    int                 anchor[NUM_PAT];
    logic [MAX_LEN-1:0] m_pat[NUM_PAT];
    int                 m_len[NUM_PAT];
    bit                 m_ovl[NUM_PAT];
    bit                 m_en[NUM_PAT];
    int                 m_cnt[NUM_PAT];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic bit tail_match(int p);
        int n;
        n = bits.size();
        if (m_len[p] < 1 || m_len[p] > MAX_LEN) return 1'b0;
        if (nbits < m_len[p]) return 1'b0;
        for (int k = 0; k < m_len[p]; k++)
            if (bits[n-1-k] != m_pat[p][k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        bits.delete();
        nbits = 0;
        for (int p = 0; p < NUM_PAT; p++) begin
            anchor[p] = -1000;
            m_pat[p]  = '0;
            m_len[p]  = 0;
            m_ovl[p]  = 1'b0;
            m_en[p]   = 1'b0;
            m_cnt[p]  = 0;
        end
    endtask

    task automatic step(input bit xv, input bit xb, input bit we,
                        input int idx, input logic [MAX_LEN-1:0] pat,
                        input int len, input bit ovl, input bit en,
                        input bit clr);
        exp_t               e;
        logic [NUM_PAT-1:0] h;
        @(negedge clk);
        x_valid     = xv;
        x           = xb;
        cfg_we      = we;
        cfg_idx     = IDX_W'(idx);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_en      = en;
        clr_count   = clr;
        if (xv) begin
            bits.push_back(xb);
            nbits++;
        end
        for (int p = 0; p < NUM_PAT; p++)
            h[p] = xv && m_en[p] && tail_match(p) &&
                   (m_ovl[p] || (nbits - anchor[p] >= m_len[p]));
        e.hit = h;
        e.any = |h;
        for (int p = 0; p < NUM_PAT; p++)
            e.cnt[p*CNT_W +: CNT_W] = CNT_W'(m_cnt[p]);
        sbq.push_back(e);
        for (int p = 0; p < NUM_PAT; p++) begin
            if (clr) m_cnt[p] = 0;
            else if (h[p] && m_cnt[p] < CNT_MAX) m_cnt[p]++;
            if (h[p]) anchor[p] = nbits;
            if (we && idx == p) begin
                m_pat[p]  = pat;
                m_len[p]  = len;
                m_ovl[p]  = ovl;
                m_en[p]   = en;
                anchor[p] = nbits;
            end
        end
        if (bits.size() > MAX_LEN) void'(bits.pop_front());
    endtask

    task automatic wr(input int idx, input logic [MAX_LEN-1:0] pat,
                      input int len, input bit ovl, input bit en);
        step(0, 0, 1, idx, pat, len, ovl, en, 0);
    endtask

    task automatic sb(input bit b);
        step(1, b, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        x_valid     = 1'b0;
        cfg_we      = 1'b0;
        clr_count   = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_hit", 64'(hit), 64'd0);
        chk("reset_count", 64'(hit_count), 64'd0);
        reset = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents hit/hit_any/hit_count,
    // settled just before the active edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("hit", 64'(hit), 64'(e.hit));
            chk("hit_any", 64'(hit_any), 64'(e.any));
            chk("hit_count", 64'(hit_count), 64'(e.cnt));
        end
    end

    initial begin
        int wait_cyc;
        model_reset();

        // unconfigured: random stream never hits
        do_reset();
        for (int i = 0; i < 100; i++) sb(1'($urandom));
        idle();

        // 010 and 1001, overlapping
        do_reset();
        wr(0, 8'b010, 3, 1, 1);
        wr(1, 8'b1001, 4, 1, 1);
        sb(0); sb(1); sb(0); sb(0); sb(1);
        idle();

        // 101 overlap vs non-overlap
        do_reset();
        wr(0, 8'b101, 3, 1, 1);
        sb(1); sb(0); sb(1); sb(0); sb(1);
        idle();
        do_reset();
        wr(0, 8'b101, 3, 0, 1);
        sb(1); sb(0); sb(1); sb(0); sb(1);
        idle();

        // zero pattern needs a full history; gaps hold state
        do_reset();
        wr(0, 8'b000, 3, 1, 1);
        sb(0); idle(); sb(0); idle(); idle(); sb(0); sb(0);
        idle();

        // rewrite on the cycle of an old match
        do_reset();
        wr(0, 8'b101, 3, 1, 1);
        sb(1); sb(0);
        step(1, 1, 1, 0, 8'b110, 3, 0, 1, 0);
        sb(1); sb(0); sb(1); sb(1); sb(0);
        idle();

        // saturation, then clear against a same-cycle hit
        do_reset();
        wr(0, 8'b1, 1, 1, 1);
        for (int i = 0; i < 5; i++) sb(1);
        step(1, 1, 0, 0, '0, 0, 0, 0, 1);
        idle();
        sb(1);
        idle();

        // over-long length never hits, disabled slot never hits
        do_reset();
        wr(0, 8'b0, 12, 1, 1);
        wr(1, 8'b1, 1, 1, 0);
        for (int i = 0; i < 20; i++) sb(1'($urandom));
        idle();

        // random traffic with occasional rewrites, clears and a reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int len;
            if (i == 1500) do_reset();
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                              : $urandom_range(1, 4);
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, NUM_PAT - 1),
                 MAX_LEN'($urandom), len, 1'($urandom),
                 $urandom_range(0, 5) != 0,
                 $urandom_range(0, 99) == 0);
        end
        idle();

        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        #6;
        chk("drain", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
